// File: rtl/flash_prefetch_buffer_if.sv
// -----------------------------------------------------------------------------
// flash_prefetch_buffer_if
// Groups the CPU native memory bus and the flash cache read/write port that
// the prefetch buffer sits between.
//
// CPU side (picoRV native bus):
//   cpu_valid/cpu_instr/cpu_addr/cpu_wstrb/cpu_wdata : request, held by the CPU
//   cpu_ready/cpu_rdata                              : one-cycle completion
// Flash cache side:
//   fl_select/fl_wstrb/fl_addr/fl_wdata : request towards the cache
//   fl_ready/fl_data                    : one-cycle completion from the cache
//
// Handshake semantics (both sides): a requester raises its valid/select and
// holds the request fields stable until the responder returns a single-cycle
// ready pulse; read data is only meaningful in that ready cycle. The requester
// drops its request in the cycle after the pulse (the buffer drops fl_select
// combinationally in the fl_ready cycle itself).
//
// Modports:
//   slave  : the prefetch buffer (serves the CPU, drives the cache)
//   master : the environment (CPU plus flash cache)
// -----------------------------------------------------------------------------
interface flash_prefetch_buffer_if;
    logic        cpu_valid;
    logic        cpu_instr;
    logic [14:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    logic        fl_select;
    logic [3:0]  fl_wstrb;
    logic [14:0] fl_addr;
    logic [31:0] fl_wdata;
    logic        fl_ready;
    logic [31:0] fl_data;

    modport slave (
        input  cpu_valid, cpu_instr, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_ready, cpu_rdata,
        output fl_select, fl_wstrb, fl_addr, fl_wdata,
        input  fl_ready, fl_data
    );

    modport master (
        output cpu_valid, cpu_instr, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        input  fl_select, fl_wstrb, fl_addr, fl_wdata,
        output fl_ready, fl_data
    );
endinterface

// File: rtl/flash_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// flash_prefetch_buffer
// One-entry sequential prefetch buffer between the picoRV native memory bus
// and the cached user-flash port. Every CPU access is forwarded to the cache;
// after a qualifying read the next word is fetched speculatively so that a
// following sequential fetch completes one cycle after it is accepted.
//
// Parameters:
//   PREFETCH_DATA : 1 = prefetch after data reads too, 0 = instruction reads only
//   LAST_WORD     : highest valid flash word address; nothing is prefetched past it
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : CPU and flash cache buses (slave modport)
//   pf_hit        : pulse, request served from the prefetch entry
//   pf_discard    : pulse, a valid prefetch entry was dropped unused
//   dbg_state     : current FSM state
//   dbg_pf_valid  : prefetch entry valid
//   dbg_pf_addr   : prefetch entry address
// -----------------------------------------------------------------------------
module flash_prefetch_buffer #(
    parameter bit          PREFETCH_DATA = 1'b0,
    parameter logic [14:0] LAST_WORD     = 15'd19455
) (
    input  logic                    clk,
    input  logic                    reset_n,
    flash_prefetch_buffer_if.slave  bus,
    output logic                    pf_hit,
    output logic                    pf_discard,
    output logic [1:0]              dbg_state,
    output logic                    dbg_pf_valid,
    output logic [14:0]             dbg_pf_addr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_PREFETCH = 2'd2,
        ST_RESPOND  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] cpu_rdata_q,  cpu_rdata_d;
    logic [3:0]  fl_wstrb_q,   fl_wstrb_d;
    logic [14:0] fl_addr_q,    fl_addr_d;
    logic [31:0] fl_wdata_q,   fl_wdata_d;
    logic        pf_hit_q,     pf_hit_d;
    logic        pf_discard_q, pf_discard_d;
    logic        pf_valid_q,   pf_valid_d;
    logic [14:0] pf_addr_q,    pf_addr_d;
    logic [31:0] pf_data_q,    pf_data_d;
    // Attributes of the request currently being served; RESPOND needs them
    // to decide on a prefetch even when the request never reached the cache.
    logic [14:0] req_addr_q,   req_addr_d;
    logic        req_read_q,   req_read_d;
    logic        req_instr_q,  req_instr_d;

    logic        cpu_read;
    logic        pf_match;
    logic        prefetch_ok;

    assign cpu_read    = (bus.cpu_wstrb == 4'h0);
    assign pf_match    = pf_valid_q && (pf_addr_q == bus.cpu_addr);
    // The upper bound keeps the increment from leaving the flash array.
    assign prefetch_ok = req_read_q && (req_instr_q || PREFETCH_DATA)
                         && (req_addr_q < LAST_WORD);

    always_comb begin
        state_d      = state_q;
        cpu_rdata_d  = cpu_rdata_q;
        fl_wstrb_d   = fl_wstrb_q;
        fl_addr_d    = fl_addr_q;
        fl_wdata_d   = fl_wdata_q;
        pf_hit_d     = 1'b0;
        pf_discard_d = 1'b0;
        pf_valid_d   = pf_valid_q;
        pf_addr_d    = pf_addr_q;
        pf_data_d    = pf_data_q;
        req_addr_d   = req_addr_q;
        req_read_d   = req_read_q;
        req_instr_d  = req_instr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_valid) begin
                    req_addr_d  = bus.cpu_addr;
                    req_read_d  = cpu_read;
                    req_instr_d = bus.cpu_instr;
                    if (cpu_read && pf_match) begin
                        cpu_rdata_d = pf_data_q;
                        pf_hit_d    = 1'b1;
                        pf_valid_d  = 1'b0;
                        state_d     = ST_RESPOND;
                    end else begin
                        // Any miss or write consumes the entry: a write may
                        // alias it and a miss means the stream moved on.
                        if (pf_valid_q) begin
                            pf_valid_d   = 1'b0;
                            pf_discard_d = 1'b1;
                        end
                        fl_addr_d  = bus.cpu_addr;
                        fl_wstrb_d = bus.cpu_wstrb;
                        if (!cpu_read) begin
                            fl_wdata_d = bus.cpu_wdata;
                        end
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                if (bus.fl_ready) begin
                    if (req_read_q) begin
                        cpu_rdata_d = bus.fl_data;
                    end
                    state_d = ST_RESPOND;
                end
            end

            ST_RESPOND: begin
                if (prefetch_ok) begin
                    fl_addr_d  = req_addr_q + 15'd1;
                    fl_wstrb_d = 4'h0;
                    state_d    = ST_PREFETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PREFETCH: begin
                // Runs to completion; a waiting CPU request is looked at in
                // IDLE afterwards and can hit on the entry stored here.
                if (bus.fl_ready) begin
                    pf_data_d  = bus.fl_data;
                    pf_addr_d  = fl_addr_q;
                    pf_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cpu_rdata_q  <= 32'h0;
            fl_wstrb_q   <= 4'h0;
            fl_addr_q    <= 15'h0;
            fl_wdata_q   <= 32'h0;
            pf_hit_q     <= 1'b0;
            pf_discard_q <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_addr_q    <= 15'h0;
            pf_data_q    <= 32'h0;
            req_addr_q   <= 15'h0;
            req_read_q   <= 1'b0;
            req_instr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rdata_q  <= cpu_rdata_d;
            fl_wstrb_q   <= fl_wstrb_d;
            fl_addr_q    <= fl_addr_d;
            fl_wdata_q   <= fl_wdata_d;
            pf_hit_q     <= pf_hit_d;
            pf_discard_q <= pf_discard_d;
            pf_valid_q   <= pf_valid_d;
            pf_addr_q    <= pf_addr_d;
            pf_data_q    <= pf_data_d;
            req_addr_q   <= req_addr_d;
            req_read_q   <= req_read_d;
            req_instr_q  <= req_instr_d;
        end
    end

    // Dropping select in the fl_ready cycle keeps the cache from seeing a
    // second request for a transfer that has just completed.
    assign bus.fl_select = ((state_q == ST_FETCH) || (state_q == ST_PREFETCH))
                           && !bus.fl_ready;
    assign bus.fl_wstrb  = fl_wstrb_q;
    assign bus.fl_addr   = fl_addr_q;
    assign bus.fl_wdata  = fl_wdata_q;
    assign bus.cpu_ready = (state_q == ST_RESPOND);
    assign bus.cpu_rdata = cpu_rdata_q;

    assign pf_hit       = pf_hit_q;
    assign pf_discard   = pf_discard_q;
    assign dbg_state    = state_q;
    assign dbg_pf_valid = pf_valid_q;
    assign dbg_pf_addr  = pf_addr_q;

endmodule

// File: tb/tb_flash_prefetch_buffer.sv
module tb_flash_prefetch_buffer;

  localparam logic [14:0] LAST_WORD = 15'd19455;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  flash_prefetch_buffer_if bus ();
  flash_prefetch_buffer_if bus_pd ();

  logic        pf_hit, pf_discard, dbg_pf_valid;
  logic [1:0]  dbg_state;
  logic [14:0] dbg_pf_addr;
  logic        pd_pf_hit, pd_pf_discard, pd_pf_valid;
  logic [1:0]  pd_state;
  logic [14:0] pd_pf_addr;

  flash_prefetch_buffer #(.PREFETCH_DATA(1'b0), .LAST_WORD(LAST_WORD)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .pf_hit       (pf_hit),
    .pf_discard   (pf_discard),
    .dbg_state    (dbg_state),
    .dbg_pf_valid (dbg_pf_valid),
    .dbg_pf_addr  (dbg_pf_addr)
  );

  flash_prefetch_buffer #(.PREFETCH_DATA(1'b1), .LAST_WORD(LAST_WORD)) u_dut_pd (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_pd),
    .pf_hit       (pd_pf_hit),
    .pf_discard   (pd_pf_discard),
    .dbg_state    (pd_state),
    .dbg_pf_valid (pd_pf_valid),
    .dbg_pf_addr  (pd_pf_addr)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash contents (shared by both cache models) ----------------
  logic [31:0] mem [logic [14:0]];

  function automatic logic [31:0] rd(input logic [14:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, 2'b10, ~a};
  endfunction

  // ---------------- cache model for the main instance ----------------
  // Entries: {wstrb, addr, wdata (0 for reads)}
  logic [50:0] act_q[$];
  logic [50:0] exp_q[$];
  int          cache_lat = 3;
  int          busy = 0;
  int          remaining = 0;
  logic [14:0] start_addr;

  initial begin
    logic [31:0] m;
    bus.fl_ready = 1'b0;
    bus.fl_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy = 0;
        bus.fl_ready = 1'b0;
      end else if (bus.fl_ready) begin
        bus.fl_ready = 1'b0;
      end else if (bus.fl_select) begin
        if (busy == 0) begin
          busy = 1;
          remaining = cache_lat;
          start_addr = bus.fl_addr;
        end
        remaining--;
        if (remaining <= 0) begin
          check("fl_addr_stable", bus.fl_addr, start_addr);
          if (bus.fl_wstrb != 4'h0) begin
            m = rd(bus.fl_addr);
            for (int i = 0; i < 4; i++)
              if (bus.fl_wstrb[i]) m[8*i +: 8] = bus.fl_wdata[8*i +: 8];
            mem[bus.fl_addr] = m;
            act_q.push_back({bus.fl_wstrb, bus.fl_addr, bus.fl_wdata});
          end else begin
            bus.fl_data = rd(bus.fl_addr);
            act_q.push_back({4'h0, bus.fl_addr, 32'h0});
          end
          bus.fl_ready = 1'b1;
          busy = 0;
        end
      end
    end
  end

  // ---------------- cache model for the PREFETCH_DATA=1 instance ----------------
  initial begin
    bus_pd.fl_ready = 1'b0;
    bus_pd.fl_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n || bus_pd.fl_ready) begin
        bus_pd.fl_ready = 1'b0;
      end else if (bus_pd.fl_select) begin
        bus_pd.fl_data  = rd(bus_pd.fl_addr);
        bus_pd.fl_ready = 1'b1;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic        m_pf_valid = 1'b0;
  logic [14:0] m_pf_addr  = 15'h0;
  logic [31:0] m_pf_data  = 32'h0;
  logic [31:0] m_rdata    = 32'h0;
  bit          m_pf_data_mode = 1'b0;

  task automatic drain_scoreboard();
    logic [50:0] a, e;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 51'h7_FFFF_FFFF_FFFF;
      check("cache_txn", a, e);
    end
  endtask

  // ---------------- CPU driver with model update ----------------
  task automatic do_req(input logic [14:0] addr, input logic instr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
    logic        is_read, exp_hit, exp_disc, was_idle;
    logic [31:0] exp_rdata;
    int          cycles, hits, discs;
    @(posedge clk); #1;
    was_idle  = (dbg_state == 2'd0);
    is_read   = (wstrb == 4'h0);
    exp_hit   = is_read && m_pf_valid && (m_pf_addr == addr);
    exp_disc  = !exp_hit && m_pf_valid;
    exp_rdata = exp_hit ? m_pf_data : (is_read ? rd(addr) : m_rdata);
    if (!exp_hit) exp_q.push_back({wstrb, addr, is_read ? 32'h0 : wdata});
    bus.cpu_valid = 1'b1;
    bus.cpu_instr = instr;
    bus.cpu_addr  = addr;
    bus.cpu_wstrb = wstrb;
    bus.cpu_wdata = wdata;
    cycles = 0; hits = 0; discs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cycles++;
      hits  += int'(pf_hit);
      discs += int'(pf_discard);
      if (bus.cpu_ready) break;
    end
    check("cpu_ready_seen", bus.cpu_ready, 1'b1);
    check("cpu_rdata", bus.cpu_rdata, exp_rdata);
    check("pf_hit_count", hits, exp_hit ? 1 : 0);
    check("pf_discard_count", discs, exp_disc ? 1 : 0);
    // First negedge falls before the sampling edge, so a hit answers on the second.
    if (exp_hit && was_idle) check("hit_latency", cycles, 2);
    m_rdata    = exp_rdata;
    m_pf_valid = 1'b0;
    if (is_read && (instr || m_pf_data_mode) && addr < LAST_WORD) begin
      m_pf_valid = 1'b1;
      m_pf_addr  = addr + 15'd1;
      m_pf_data  = rd(addr + 15'd1);
      exp_q.push_back({4'h0, addr + 15'd1, 32'h0});
    end
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    check("cpu_ready_one_pulse", bus.cpu_ready, 1'b0);
    drain_scoreboard();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (dbg_state == 2'd0 && !bus.fl_ready) break;
      @(negedge clk);
    end
    check("idle_reached", dbg_state, 2'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [14:0] addr, prev;
    logic [3:0]  ws;
    int          cycles, hits;
    bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wstrb = '0;   bus.cpu_wdata = '0;
    bus_pd.cpu_valid = 1'b0; bus_pd.cpu_instr = 1'b0; bus_pd.cpu_addr = '0;
    bus_pd.cpu_wstrb = '0;   bus_pd.cpu_wdata = '0;

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_fl_select", bus.fl_select, 1'b0);
    check("rst_fl_addr", bus.fl_addr, 15'h0);
    check("rst_fl_wstrb", bus.fl_wstrb, 4'h0);
    check("rst_fl_wdata", bus.fl_wdata, 32'h0);
    check("rst_pf_hit", pf_hit, 1'b0);
    check("rst_pf_discard", pf_discard, 1'b0);
    check("rst_pf_valid", dbg_pf_valid, 1'b0);
    check("rst_pf_addr", dbg_pf_addr, 15'h0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Demand instruction read, slow cache, prefetch follows
    mem[15'h0040] = 32'h11223344;
    cache_lat = 20;
    do_req(15'h0040, 1'b1, 4'h0, 32'h0);
    check("t1_rdata_const", m_rdata, 32'h11223344);
    check("t1_pf_select", bus.fl_select, 1'b1);
    check("t1_pf_addr_out", bus.fl_addr, 15'h0041);
    wait_idle();
    check("t1_pf_valid", dbg_pf_valid, 1'b1);
    check("t1_pf_addr", dbg_pf_addr, 15'h0041);

    // Sequential hit, next prefetch launched
    cache_lat = 4;
    do_req(15'h0041, 1'b1, 4'h0, 32'h0);
    check("t2_pf_select", bus.fl_select, 1'b1);
    check("t2_pf_addr_out", bus.fl_addr, 15'h0042);
    wait_idle();
    check("t2_pf_addr", dbg_pf_addr, 15'h0042);

    // Non-sequential read drops the entry
    do_req(15'h0100, 1'b1, 4'h0, 32'h0);
    wait_idle();
    check("t3_pf_addr", dbg_pf_addr, 15'h0101);

    // Write to the prefetched address invalidates and does not prefetch
    do_req(15'h0041, 1'b1, 4'h0, 32'h0);
    wait_idle();
    check("t4_pf_addr", dbg_pf_addr, 15'h0042);
    do_req(15'h0042, 1'b1, 4'hF, 32'hDEADBEEF);
    check("t4_no_prefetch", bus.fl_select, 1'b0);
    check("t4_pf_valid", dbg_pf_valid, 1'b0);
    do_req(15'h0042, 1'b0, 4'h0, 32'h0);
    check("t4_written_word", m_rdata, 32'hDEADBEEF);

    // Last word: no prefetch; data read with PREFETCH_DATA=0: no prefetch
    do_req(LAST_WORD, 1'b1, 4'h0, 32'h0);
    check("t5_last_no_pf", bus.fl_select, 1'b0);
    do_req(15'h0010, 1'b0, 4'h0, 32'h0);
    check("t5_data_no_pf", bus.fl_select, 1'b0);
    check("t5_pf_valid", dbg_pf_valid, 1'b0);

    // Reset in the middle of a prefetch
    cache_lat = 20;
    do_req(15'h0040, 1'b1, 4'h0, 32'h0);
    check("t6_in_prefetch", dbg_state, 2'd2);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("t6_rst_fl_select", bus.fl_select, 1'b0);
    check("t6_rst_pf_valid", dbg_pf_valid, 1'b0);
    check("t6_rst_cpu_ready", bus.cpu_ready, 1'b0);
    exp_q.delete();
    act_q.delete();
    m_pf_valid = 1'b0;
    m_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cache_lat = 3;
    do_req(15'h0041, 1'b1, 4'h0, 32'h0);
    wait_idle();

    // Randomised traffic
    prev = 15'h0040;
    for (int n = 0; n < 80; n++) begin
      cache_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 3) != 0 && prev < LAST_WORD) addr = prev + 15'd1;
      else if ($urandom_range(0, 4) == 0) addr = LAST_WORD - 15'($urandom_range(0, 2));
      else addr = 15'($urandom_range(0, 63));
      ws = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_req(addr, ($urandom_range(0, 3) != 0), ws, $urandom);
      prev = addr;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    @(negedge clk);
    drain_scoreboard();
    check("scoreboard_empty", exp_q.size(), 0);

    // PREFETCH_DATA=1 instance: data read prefetches the next word
    @(posedge clk); #1;
    bus_pd.cpu_valid = 1'b1; bus_pd.cpu_instr = 1'b0;
    bus_pd.cpu_addr = 15'h0010; bus_pd.cpu_wstrb = 4'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_pd.cpu_ready) break;
    end
    check("pd_ready", bus_pd.cpu_ready, 1'b1);
    check("pd_rdata", bus_pd.cpu_rdata, rd(15'h0010));
    @(posedge clk); #1 bus_pd.cpu_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pd_pf_valid) break;
    end
    check("pd_pf_valid", pd_pf_valid, 1'b1);
    check("pd_pf_addr", pd_pf_addr, 15'h0011);
    @(posedge clk); #1;
    bus_pd.cpu_valid = 1'b1; bus_pd.cpu_addr = 15'h0011;
    cycles = 0; hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      hits += int'(pd_pf_hit);
      if (bus_pd.cpu_ready) break;
    end
    check("pd_hit_latency", cycles, 2);
    check("pd_hit_pulse", hits, 1);
    check("pd_hit_rdata", bus_pd.cpu_rdata, rd(15'h0011));
    @(posedge clk); #1 bus_pd.cpu_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_prefetch_buffer.md
Name: flash_prefetch_buffer

Overview:
- Sits between the picoRV native memory bus and the cached user-flash read port.
- Forwards CPU word accesses to the flash cache port.
- After each demand read, speculatively reads the next sequential word into a one-entry prefetch buffer.
- A following sequential instruction fetch is then served in 1 cycle instead of a cache round-trip.

Parameters:
- PREFETCH_DATA, 0, 1 = also prefetch after data reads; 0 = prefetch only after reads with cpu_instr=1
- LAST_WORD, 19455, highest valid flash word address (304 rows x 64 cols - 1); no prefetch issued beyond it

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_valid  in  1  CPU request; held until cpu_ready seen
- cpu_instr  in  1  request is an instruction fetch
- cpu_addr  in  15  word address (9b row, 6b col)
- cpu_wstrb  in  4  byte strobes; 0 = read
- cpu_wdata  in  32  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- fl_select  out  1  flash cache request
- fl_wstrb  out  4  strobes to cache
- fl_addr  out  15  word address to cache; stable while fl_select=1
- fl_wdata  out  32  write data to cache
- fl_ready  in  1  one-cycle cache completion pulse
- fl_data  in  32  cache read data, valid with fl_ready
- pf_hit  out  1  pulse: request served from prefetch buffer
- pf_discard  out  1  pulse: valid prefetch entry dropped unused

Behaviour:
- Reset (async): state=IDLE; cpu_ready=0, cpu_rdata=0, fl_wstrb=0, fl_addr=0, fl_wdata=0, pf_hit=0, pf_discard=0; pf_valid=0, pf_addr=0, pf_data=0.
- fl_select is combinational: (state==FETCH or state==PREFETCH) and !fl_ready. It drops in the fl_ready cycle, so the cache (IDLE on the next cycle) never sees a stale request.
- fl_addr, fl_wstrb and fl_wdata are registered at launch and held until fl_ready.
- States:
  - IDLE
  - FETCH (demand access to cache)
  - PREFETCH (speculative read of pf_addr)
  - RESPOND (cpu_ready=1 for exactly this cycle)
- IDLE, cpu_valid, read, pf_valid=1, pf_addr==cpu_addr (hit):
  - cpu_rdata<=pf_data; pf_hit pulse; pf_valid<=0; ->RESPOND.
  - Latency: valid sampled at edge N, cpu_ready high in cycle N+1.
  - From RESPOND, launch PREFETCH of cpu_addr+1 if eligible, else ->IDLE.
- IDLE, cpu_valid, read, miss:
  - If pf_valid=1: pf_valid<=0 and pf_discard pulse.
  - Latch fl_addr=cpu_addr, fl_wstrb=0; ->FETCH.
- IDLE, cpu_valid, write (cpu_wstrb!=0):
  - Invalidate pf_valid; pf_discard pulse only if pf_valid=1.
  - Forward strobes and data; ->FETCH.
- FETCH, fl_ready: cpu_rdata<=fl_data (write: cpu_rdata unchanged); ->RESPOND.
- RESPOND: cpu_ready=1. Next state:
  - PREFETCH with fl_addr<=last addr+1, if last op was a read, (cpu_instr or PREFETCH_DATA), and addr<LAST_WORD.
  - Otherwise IDLE.
- PREFETCH, fl_ready: pf_data<=fl_data, pf_addr<=fl_addr, pf_valid<=1; ->IDLE.
  - A prefetch is never aborted (the cache cannot abort).
  - A cpu_valid arriving during PREFETCH waits. It is evaluated in IDLE on the following cycle and may hit on the freshly stored entry.
- CPU request handling:
  - CPU deasserts cpu_valid the cycle after cpu_ready, so IDLE never re-accepts a served request.
  - cpu_valid is never sampled outside IDLE.
- Address arithmetic:
  - 15-bit unsigned increment.
  - At cpu_addr==LAST_WORD: no prefetch, no wrap to 0.
- Simultaneous events:
  - fl_ready and cpu_valid in the same PREFETCH cycle: store the entry first; the request is handled next cycle in IDLE.
- Reset mid-transaction:
  - Everything returns to reset values immediately; fl_select falls asynchronously.
  - Any outstanding cache transaction is abandoned. The cache is reset by the same reset_n.

Test Plan:
- Reset, then instruction read 0x0040, cache returns 0x11223344 after 20 cycles -> one cpu_ready with 0x11223344; fl_addr then 0x0041 with fl_select high; pf_valid=1, pf_addr=0x0041 after the second fl_ready.
- Then instruction read 0x0041 -> cpu_ready one cycle after cpu_valid, cpu_rdata=prefetched word, pf_hit=1, fl_select not asserted for 0x0041; prefetch of 0x0042 starts.
- With pf_addr=0x0042 valid, instruction read 0x0100 -> pf_discard pulse, demand fetch 0x0100, then prefetch 0x0101.
- Write wstrb=4'hF to 0x0042 while pf_addr=0x0042 valid -> pf_valid=0, fl_wstrb=4'hF forwarded, cpu_ready once, no prefetch issued afterward.
- Instruction read at 19455, PREFETCH_DATA=0; then data read 0x0010 -> no prefetch after 19455; no prefetch after the data read; with PREFETCH_DATA=1, 0x0011 is prefetched.
- Assert reset_n=0 mid-PREFETCH -> fl_select=0 immediately, pf_valid=0, cpu_ready=0; after release, read 0x0041 performs a full demand fetch.
